// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if
//   Bundles the producer streams and the FIFO write port seen by the
//   arbiter.
//   slave  : arbiter side (consumes req_*, fifo_full; drives the rest)
//   master : environment side (producers + FIFO)
//   req_valid/req_data/req_ready : NUM_REQ byte streams, byte i at [8i+7:8i]
//   fifo_full                    : FIFO full flag
//   fifo_data/fifo_write_en      : FIFO write port
//   grant_id/beat_count          : last granted producer, forwarded byte count
`timescale 1ns/1ps
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 fifo_full;
  logic [7:0]           fifo_data;
  logic                 fifo_write_en;
  logic [2:0]           grant_id;
  logic [15:0]          beat_count;

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_data, fifo_write_en, grant_id, beat_count
  );

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_data, fifo_write_en, grant_id, beat_count
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter sharing one 8-bit FIFO write port among NUM_REQ
//   valid/ready producers, all in the clk1 domain. The write path is
//   combinational: the winner's byte and write_en go straight to the FIFO
//   and are captured on the same clk1 edge as the handshake, so fifo_full
//   gates ready directly and no byte is ever dropped.
//   Ports:
//     clk1   : sampling clock, all state on its rising edge
//     reset  : asynchronous active-high reset
//     bus    : fifo_write_arbiter_if.slave (producer streams, FIFO port,
//              grant_id, beat_count)
//   Parameters: NUM_REQ (2..8), MAX_BURST (1..15, burst lock only)
//   Build option: ARB_BURST_LOCK_EN -- when defined, a granted producer
//   keeps the port for up to MAX_BURST consecutive beats while it holds
//   valid (LOCK state + burst_cnt). Undefined: strict per-beat round robin.
`timescale 1ns/1ps

// Per-producer byte gate: a lane contributes its byte only when it is the
// one completing a handshake, so the output mux is a plain OR of lanes.
module fwa_lane (
  input  logic       valid,
  input  logic       ready,
  input  logic [7:0] data,
  output logic [7:0] data_o
);
  assign data_o = (valid & ready) ? data : 8'h00;
endmodule

module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input logic                  clk1,
  input logic                  reset,
  fifo_write_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           last, last_nxt;
  logic [IW-1:0]           winner, rr_idx;
  logic [NUM_REQ-1:0]      elig, ready;
  logic                    any_win, lock_hold, xfer;
  logic [NUM_REQ-1:0][7:0] lane_data;
  logic [7:0]              data_mux;
  logic [15:0]             beat_cnt;
`ifdef ARB_BURST_LOCK_EN
  logic [3:0]              burst_cnt, burst_nxt, burst_inc;
`endif

  // Owner still streaming in LOCK: it alone is eligible. If it dropped
  // valid, the cycle falls back to normal round robin.
  assign lock_hold = (state == LOCK) && bus.req_valid[last];

  always_comb begin
    elig = bus.req_valid;
    if (lock_hold) begin
      elig       = '0;
      elig[last] = 1'b1;
    end
  end

  // Rotating priority starting just after the last grant.
  always_comb begin
    any_win = 1'b0;
    winner  = '0;
    rr_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = IW'((int'(last) + 1 + k) % NUM_REQ);
      if (!any_win && elig[rr_idx]) begin
        any_win = 1'b1;
        winner  = rr_idx;
      end
    end
  end

  // Reset and full both force ready low combinationally.
  always_comb begin
    ready = '0;
    if (!reset && !bus.fifo_full && any_win)
      ready[winner] = 1'b1;
  end

  assign xfer = |(bus.req_valid & ready);

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      fwa_lane u_lane (
        .valid  (bus.req_valid[i]),
        .ready  (ready[i]),
        .data   (bus.req_data[8*i +: 8]),
        .data_o (lane_data[i])
      );
    end
  endgenerate

  always_comb begin
    data_mux = 8'h00;
    for (int i = 0; i < NUM_REQ; i++)
      data_mux = data_mux | lane_data[i];
  end

  assign bus.req_ready     = ready;
  assign bus.fifo_write_en = xfer;
  assign bus.fifo_data     = data_mux;
  assign bus.grant_id      = 3'(last);
  assign bus.beat_count    = beat_cnt;

  // Next-state / grant bookkeeping.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
`ifdef ARB_BURST_LOCK_EN
    burst_nxt = burst_cnt;
    burst_inc = burst_cnt + 4'd1;
    if (xfer) begin
      if (lock_hold) begin
        burst_nxt = burst_inc;
        if (burst_inc >= 4'(MAX_BURST))
          state_nxt = IDLE;
      end else begin
        // Fresh grant (from IDLE, or LOCK released this cycle).
        last_nxt  = winner;
        burst_nxt = 4'd1;
        state_nxt = (MAX_BURST > 1) ? LOCK : IDLE;
      end
    end else if (state == LOCK && !lock_hold) begin
      state_nxt = IDLE;
    end
    // fifo_full with lock_hold: no xfer, lock and burst_cnt held.
`else
    state_nxt = IDLE;
    if (xfer)
      last_nxt = winner;
`endif
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= IW'(NUM_REQ - 1);
      beat_cnt  <= 16'h0000;
`ifdef ARB_BURST_LOCK_EN
      burst_cnt <= 4'd0;
`endif
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      if (xfer && beat_cnt != 16'hFFFF)
        beat_cnt <= beat_cnt + 16'd1;
`ifdef ARB_BURST_LOCK_EN
      burst_cnt <= burst_nxt;
`endif
    end
  end
endmodule
